// File: rtl/csr_unit.sv
// Machine-mode CSR file: status/trap CSRs, 64-bit cycle and instret counters,
// trap entry and mret sequencing for the single-cycle core.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCsrEn,
    input  logic [2:0]  iFunct3,
    input  logic [11:0] iCsrAddr,
    input  logic [31:0] iOperand,
    input  logic        iSrcZero,
    input  logic        iRetire,
    input  logic        iTrap,
    input  logic [31:0] iTrapCause,
    input  logic [31:0] iTrapPC,
    input  logic        iMret,
    output logic [31:0] oRdata,
    output logic [31:0] oTrapVector,
    output logic [31:0] oEpc,
    output logic        oIllegal,
    output logic        oMIE
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mscratch;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        mapped;
    logic        read_only;
    logic        write_req;
    logic        illegal;
    logic        wr;
    logic [31:0] old_val;
    logic [31:0] wdata;

    always_comb begin
        mapped  = 1'b1;
        old_val = 32'h0;
        case (iCsrAddr)
            A_MSTATUS:               old_val = {24'h0, mpie, 3'b000, mie, 3'b000};
            A_MTVEC:                 old_val = mtvec;
            A_MSCRATCH:              old_val = mscratch;
            A_MEPC:                  old_val = mepc;
            A_MCAUSE:                old_val = mcause;
            A_MCYCLE, A_CYCLE:       old_val = mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:     old_val = mcycle[63:32];
            A_MINSTRET, A_INSTRET:   old_val = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: old_val = minstret[63:32];
            A_MHARTID:               old_val = HART_ID;
            default:                 mapped  = 1'b0;
        endcase
    end

    // RW/RWI always write; set/clear forms only write with a nonzero source.
    assign write_req = iCsrEn && ((iFunct3[1:0] == 2'b01) || (iFunct3[1] && !iSrcZero));
    assign read_only = (iCsrAddr[11:8] == 4'hC) || (iCsrAddr == A_MHARTID);
    assign illegal   = iCsrEn && !iRST && (!mapped || (write_req && read_only));
    assign wr        = write_req && !illegal && !iTrap && !iRST;

    always_comb begin
        wdata = iOperand;
        case (iFunct3[1:0])
            2'b10:   wdata = old_val | iOperand;
            // RCI operand arrives already inverted, so it is applied as a plain mask.
            2'b11:   wdata = iFunct3[2] ? (old_val & iOperand) : (old_val & ~iOperand);
            default: wdata = iOperand;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET & ALIGN_MASK;
            mepc     <= 32'h0;
            mcause   <= 32'h0;
            mscratch <= 32'h0;
            mcycle   <= 64'h0;
            minstret <= 64'h0;
        end else begin
            if (iTrap) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (iMret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (wr && iCsrAddr == A_MSTATUS) begin
                mie  <= wdata[3];
                mpie <= wdata[7];
            end

            if (wr && iCsrAddr == A_MTVEC)    mtvec    <= wdata & ALIGN_MASK;
            if (wr && iCsrAddr == A_MSCRATCH) mscratch <= wdata;

            if (iTrap) begin
                mepc   <= iTrapPC & ALIGN_MASK;
                mcause <= iTrapCause;
            end else begin
                if (wr && iCsrAddr == A_MEPC)   mepc   <= wdata & ALIGN_MASK;
                if (wr && iCsrAddr == A_MCAUSE) mcause <= wdata;
            end

            // A write to either half freezes the whole counter for that cycle.
            if (wr && iCsrAddr == A_MCYCLE)
                mcycle <= {mcycle[63:32], wdata};
            else if (wr && iCsrAddr == A_MCYCLEH)
                mcycle <= {wdata, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (wr && iCsrAddr == A_MINSTRET)
                minstret <= {minstret[63:32], wdata};
            else if (wr && iCsrAddr == A_MINSTRETH)
                minstret <= {wdata, minstret[31:0]};
            else if (iRetire && !iTrap)
                minstret <= minstret + 64'd1;
        end
    end

    assign oRdata      = (iCsrEn && !illegal && !iRST) ? old_val : 32'h0;
    assign oIllegal    = illegal;
    assign oTrapVector = mtvec;
    assign oEpc        = mepc;
    assign oMIE        = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: CSR ops, counters, trap/mret, illegal
// accesses and asynchronous reset.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] HART      = 32'h0000_0007;

    logic        clk;
    logic        rst;
    logic        iCsrEn;
    logic [2:0]  iFunct3;
    logic [11:0] iCsrAddr;
    logic [31:0] iOperand;
    logic        iSrcZero;
    logic        iRetire;
    logic        iTrap;
    logic [31:0] iTrapCause;
    logic [31:0] iTrapPC;
    logic        iMret;
    logic [31:0] oRdata;
    logic [31:0] oTrapVector;
    logic [31:0] oEpc;
    logic        oIllegal;
    logic        oMIE;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] got_rdata;
    logic        got_illegal;
    int          checks;
    int          errors;

    csr_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .iCLK(clk), .iRST(rst), .iCsrEn(iCsrEn), .iFunct3(iFunct3),
        .iCsrAddr(iCsrAddr), .iOperand(iOperand), .iSrcZero(iSrcZero),
        .iRetire(iRetire), .iTrap(iTrap), .iTrapCause(iTrapCause),
        .iTrapPC(iTrapPC), .iMret(iMret), .oRdata(oRdata),
        .oTrapVector(oTrapVector), .oEpc(oEpc), .oIllegal(oIllegal), .oMIE(oMIE)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // driver: one CSR instruction for one cycle; outputs captured mid-cycle
    task automatic csr_cycle(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] op, input logic sz);
        @(negedge clk);
        iCsrEn = 1'b1; iFunct3 = f3; iCsrAddr = addr; iOperand = op; iSrcZero = sz;
        #2;
        got_rdata   = oRdata;
        got_illegal = oIllegal;
        @(posedge clk);
        #1;
        iCsrEn = 1'b0; iOperand = 32'h0; iSrcZero = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        iCsrEn = 1'b1; iFunct3 = 3'b010; iCsrAddr = 12'hF14; iSrcZero = 1'b1;
        #1;
        checks++; if (oRdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want %h", oRdata, 32'h0); end
        checks++; if (oTrapVector !== 32'h0000_1000) begin errors++; $display("FAIL rst_tvec: got %h want %h", oTrapVector, 32'h0000_1000); end
        checks++; if (oEpc !== 32'h0) begin errors++; $display("FAIL rst_epc: got %h want 0", oEpc); end
        checks++; if (oIllegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", oIllegal); end
        checks++; if (oMIE !== 1'b0) begin errors++; $display("FAIL rst_mie: got %b want 0", oMIE); end
        @(negedge clk);
        rst = 1'b0; iCsrEn = 1'b0; iSrcZero = 1'b0;
        repeat (10) @(posedge clk);
        exp_q.push_back(32'd10);
        csr_cycle(3'b010, 12'hC00, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL cycle_after_10: got %0d want %0d", got_rdata, exp_v); end
        checks++; if (got_illegal !== 1'b0) begin errors++; $display("FAIL cycle_read_illegal: got %b want 0", got_illegal); end
        exp_q.push_back(32'd0);
        csr_cycle(3'b010, 12'hB02, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL minstret_zero: got %h want %h", got_rdata, exp_v); end
    endtask

    task automatic test_rw_ops();
        logic [2:0]  f3 [6] = '{3'b001, 3'b010, 3'b111, 3'b010, 3'b001, 3'b011};
        logic [11:0] ad [6] = '{12'h340, 12'h340, 12'h340, 12'h340, 12'h342, 12'h342};
        logic [31:0] op [6] = '{32'hDEADBEEF, 32'h0000_0F00, ~32'd5, 32'h0, 32'h0000_00FF, 32'h0000_000F};
        logic        sz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ex [6] = '{32'h0, 32'hDEADBEEF, 32'hDEADBFEF, 32'hDEADBFEA, 32'h0, 32'h0000_00FF};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex[i]);
            csr_cycle(f3[i], ad[i], op[i], sz[i]);
            exp_v = exp_q.pop_front();
            checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL rw_op%0d: got %h want %h", i, got_rdata, exp_v); end
        end
        exp_q.push_back(32'h0000_00F0);
        csr_cycle(3'b010, 12'h342, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL rc_result: got %h want %h", got_rdata, exp_v); end
    endtask

    task automatic test_counters();
        logic [11:0] ad [3] = '{12'hB00, 12'hB80, 12'hC00};
        logic [31:0] ex [3] = '{32'hFFFF_FFFF, 32'd2, 32'd1};
        csr_cycle(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        exp_q.push_back(32'h0);
        csr_cycle(3'b001, 12'hB80, 32'h1, 1'b0);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mcycleh_old: got %h want %h", got_rdata, exp_v); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            csr_cycle(3'b010, ad[i], 32'h0, 1'b1);
            exp_v = exp_q.pop_front();
            checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mcycle_carry%0d: got %h want %h", i, got_rdata, exp_v); end
        end
        exp_q.push_back(32'h0);
        csr_cycle(3'b001, 12'hB02, 32'hFFFF_FFFE, 1'b0);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL minstret_old: got %h want %h", got_rdata, exp_v); end
        @(negedge clk); iRetire = 1'b1;
        repeat (3) @(negedge clk);
        iRetire = 1'b0;
        exp_q.push_back(32'd1);
        csr_cycle(3'b010, 12'hC02, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL instret_lo: got %h want %h", got_rdata, exp_v); end
        exp_q.push_back(32'd1);
        csr_cycle(3'b010, 12'hC82, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL instret_hi: got %h want %h", got_rdata, exp_v); end
    endtask

    task automatic test_trap_mret();
        exp_q.push_back(32'h0);
        csr_cycle(3'b110, 12'h300, 32'h8, 1'b0);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mstatus_old: got %h want %h", got_rdata, exp_v); end
        checks++; if (oMIE !== 1'b1) begin errors++; $display("FAIL mie_set: got %b want 1", oMIE); end
        // trap with a retiring instruction and a concurrent mscratch write
        iTrap = 1'b1; iTrapCause = 32'h8000_000B; iTrapPC = 32'h0040_0126; iRetire = 1'b1;
        exp_q.push_back(32'hDEADBFEA);
        csr_cycle(3'b001, 12'h340, 32'h1234_5678, 1'b0);
        iTrap = 1'b0; iRetire = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL trap_cycle_rd: got %h want %h", got_rdata, exp_v); end
        checks++; if (oEpc !== 32'h0040_0124) begin errors++; $display("FAIL trap_epc: got %h want %h", oEpc, 32'h0040_0124); end
        checks++; if (oMIE !== 1'b0) begin errors++; $display("FAIL trap_mie: got %b want 0", oMIE); end
        begin
            logic [11:0] ad [4] = '{12'h342, 12'h300, 12'h340, 12'hC02};
            logic [31:0] ex [4] = '{32'h8000_000B, 32'h0000_0080, 32'hDEADBFEA, 32'd1};
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ex[i]);
                csr_cycle(3'b010, ad[i], 32'h0, 1'b1);
                exp_v = exp_q.pop_front();
                checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL post_trap%0d: got %h want %h", i, got_rdata, exp_v); end
            end
        end
        // mret alongside a write of 0 to mstatus: mret result must win
        iMret = 1'b1;
        exp_q.push_back(32'h0000_0080);
        csr_cycle(3'b001, 12'h300, 32'h0, 1'b0);
        iMret = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mret_cycle_rd: got %h want %h", got_rdata, exp_v); end
        exp_q.push_back(32'h0000_0088);
        csr_cycle(3'b010, 12'h300, 32'h0, 1'b1);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mret_mstatus: got %h want %h", got_rdata, exp_v); end
        checks++; if (oMIE !== 1'b1) begin errors++; $display("FAIL mret_mie: got %b want 1", oMIE); end
    endtask

    task automatic test_illegal();
        logic [2:0]  f3 [6] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b011, 3'b010};
        logic [11:0] ad [6] = '{12'hC00, 12'h7C0, 12'hC00, 12'hF14, 12'hF14, 12'hC00};
        logic [31:0] op [6] = '{32'h0, 32'h1, 32'h0, 32'h5, 32'h5, 32'h3};
        logic        sz [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ex [6] = '{32'h0, 32'h0, 32'h102, 32'h0, HART, 32'h0};
        logic        il [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        csr_cycle(3'b001, 12'hB00, 32'h100, 1'b0);
        exp_q.push_back(32'd2);
        csr_cycle(3'b001, 12'hB80, 32'h0, 1'b0);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mcycleh_pre: got %h want %h", got_rdata, exp_v); end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex[i]);
            csr_cycle(f3[i], ad[i], op[i], sz[i]);
            exp_v = exp_q.pop_front();
            checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL illegal_rd%0d: got %h want %h", i, got_rdata, exp_v); end
            checks++; if (got_illegal !== il[i]) begin errors++; $display("FAIL illegal_flag%0d: got %b want %b", i, got_illegal, il[i]); end
        end
    endtask

    task automatic test_mtvec_reset();
        exp_q.push_back(32'h0000_1000);
        csr_cycle(3'b001, 12'h305, 32'h0040_0003, 1'b0);
        exp_v = exp_q.pop_front();
        checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL mtvec_old: got %h want %h", got_rdata, exp_v); end
        checks++; if (oTrapVector !== 32'h0040_0000) begin errors++; $display("FAIL tvec_new: got %h want %h", oTrapVector, 32'h0040_0000); end
        // reset asserted in the middle of an mscratch write
        @(negedge clk);
        iCsrEn = 1'b1; iFunct3 = 3'b001; iCsrAddr = 12'h340; iOperand = 32'hAAAA_5555; iSrcZero = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (oTrapVector !== 32'h0000_1000) begin errors++; $display("FAIL midrst_tvec: got %h want %h", oTrapVector, 32'h0000_1000); end
        checks++; if (oEpc !== 32'h0) begin errors++; $display("FAIL midrst_epc: got %h want 0", oEpc); end
        checks++; if (oMIE !== 1'b0) begin errors++; $display("FAIL midrst_mie: got %b want 0", oMIE); end
        checks++; if (oRdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", oRdata); end
        checks++; if (oIllegal !== 1'b0) begin errors++; $display("FAIL midrst_illegal: got %b want 0", oIllegal); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; iCsrEn = 1'b0;
        begin
            logic [11:0] ad [4] = '{12'hB00, 12'h340, 12'hB82, 12'hB80};
            logic [31:0] ex [4] = '{32'd1, 32'h0, 32'h0, 32'h0};
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ex[i]);
                csr_cycle(3'b010, ad[i], 32'h0, 1'b1);
                exp_v = exp_q.pop_front();
                checks++; if (got_rdata !== exp_v) begin errors++; $display("FAIL post_rst%0d: got %h want %h", i, got_rdata, exp_v); end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; iCsrEn = 1'b0; iFunct3 = 3'b000; iCsrAddr = 12'h0; iOperand = 32'h0;
        iSrcZero = 1'b0; iRetire = 1'b0; iTrap = 1'b0; iTrapCause = 32'h0; iTrapPC = 32'h0;
        iMret = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_rw_ops();
        test_counters();
        test_trap_mret();
        test_illegal();
        test_mtvec_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
